// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
package display_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_NREQ        = 4;
    localparam int unsigned ARB_IDX_W       = 2;
    localparam int unsigned ARB_HOLD_CYCLES = 25000000;

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Round-robin next-owner search: first set request above i_last_owner, wrapping mod ARB_NREQ.
module rr_pick
    import display_arbiter_pkg::*;
(
    input  logic [ARB_NREQ-1:0]  i_req,
    input  logic [ARB_IDX_W-1:0] i_last_owner,
    input  logic                 i_excl_owner,
    output logic [ARB_NREQ-1:0]  o_pick,
    output logic [ARB_IDX_W-1:0] o_pick_idx,
    output logic                 o_valid
);

    logic [ARB_IDX_W-1:0] w_idx;

    // The last step of the search lands back on i_last_owner itself.
    always_comb begin
        o_pick     = '0;
        o_pick_idx = i_last_owner;
        o_valid    = 1'b0;
        w_idx      = i_last_owner;
        for (int unsigned k = 1; k <= ARB_NREQ; k++) begin
            w_idx = i_last_owner + k[ARB_IDX_W-1:0];
            if (!o_valid && i_req[w_idx] && !(i_excl_owner && k == ARB_NREQ)) begin
                o_valid    = 1'b1;
                o_pick_idx = w_idx;
            end
        end
        if (o_valid) begin
            o_pick[o_pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner arbitration of a shared 4-digit 7-segment display with minimum hold time.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int unsigned NREQ        = ARB_NREQ,
    parameter int unsigned HOLD_CYCLES = ARB_HOLD_CYCLES,
    parameter int unsigned HOLD_W      = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [16*NREQ-1:0] data,
    output logic [NREQ-1:0]    grant,
    output logic [15:0]        disp_value,
    output logic [NREQ-1:0]    disp_dp,
    output logic               disp_blank
);

    localparam logic [HOLD_W-1:0] HoldReload = HOLD_W'(HOLD_CYCLES - 1);

    arb_state_e           r_state, w_state_d;
    logic [NREQ-1:0]      r_grant, w_grant_d;
    logic [HOLD_W-1:0]    r_cnt, w_cnt_d;
    logic [ARB_IDX_W-1:0] r_last, w_last_d;
    logic [15:0]          r_value, w_value_d;
    logic                 r_blank;

    logic [NREQ-1:0]      w_pick;
    logic [ARB_IDX_W-1:0] w_pick_idx;
    logic                 w_valid;
    logic                 w_owner_req;
    logic                 w_take;

    rr_pick u_rr_pick (
        .i_req        (req),
        .i_last_owner (r_last),
        .i_excl_owner (r_state == StHold),
        .o_pick       (w_pick),
        .o_pick_idx   (w_pick_idx),
        .o_valid      (w_valid)
    );

    assign w_owner_req = |(req & r_grant);

    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_cnt_d   = r_cnt;
        w_last_d  = r_last;
        w_take    = 1'b0;
        case (r_state)
            StIdle: begin
                w_take = w_valid;
            end
            StHold: begin
                if (!w_owner_req || r_cnt == '0) begin
                    if (w_valid) begin
                        w_take = 1'b1;
                    end else if (!w_owner_req) begin
                        w_state_d = StIdle;
                        w_grant_d = '0;
                        w_cnt_d   = '0;
                    end
                    // Otherwise the sole requester keeps the display with the counter parked at 0.
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            default: ;
        endcase
        if (w_take) begin
            w_state_d = StHold;
            w_grant_d = w_pick;
            w_cnt_d   = HoldReload;
            w_last_d  = w_pick_idx;
        end
    end

    // Displayed value follows the next-cycle owner; frozen while idle.
    always_comb begin
        w_value_d = r_value;
        if (|w_grant_d) begin
            w_value_d = data[16*w_last_d +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_cnt   <= '0;
            r_last  <= ARB_IDX_W'(NREQ - 1);
            r_value <= 16'h0000;
            r_blank <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_cnt   <= w_cnt_d;
            r_last  <= w_last_d;
            r_value <= w_value_d;
            r_blank <= ~|w_grant_d;
        end
    end

    assign grant      = r_grant;
    assign disp_dp    = r_grant;
    assign disp_value = r_value;
    assign disp_blank = r_blank;

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the 7-segment display (fixed at 4 for this revision).
REQ-002 Parameter HOLD_CYCLES, default 25000000, minimum clk cycles a granted requester owns the display when others are waiting.
REQ-003 Parameter HOLD_W, default 25, width of the hold counter; HOLD_CYCLES SHALL be in the range 1 to 2^HOLD_W-1.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  4  request lines, bit i from requester i, active-high level.
REQ-007 data  in  64  display values, requester i on bits 16*i+15 to 16*i.
REQ-008 grant  out  4  one-hot current owner, all-zero when idle.
REQ-009 disp_value  out  16  value for the downstream 4-digit scan driver.
REQ-010 disp_dp  out  4  decimal-point pattern, equal to grant, so the digit position shows the owner.
REQ-011 disp_blank  out  1  high when no owner; the driver blanks all digits.

Function
REQ-012 The FSM SHALL have two states: IDLE (no owner) and HOLD (one owner).
REQ-013 IDLE with req!=0 at edge N: grant SHALL be one-hot at N+1, state HOLD, and the hold counter SHALL load HOLD_CYCLES-1.
REQ-014 Owner selection SHALL be round-robin: first set req bit searching from last_owner+1 upward, mod 4; last_owner resets to 3, so requester 0 has first priority.
REQ-015 In HOLD, the hold counter SHALL decrement by 1 per cycle and saturate at 0.
REQ-016 HOLD with the counter at 0 and a non-owner request pending: grant SHALL move to the next round-robin requester on the next edge, counter reloaded, with no idle cycle.
REQ-017 HOLD with the counter at 0 and only the owner requesting: ownership SHALL be retained, and the counter SHALL stay at 0 until a competitor appears.
REQ-018 Owner deasserts req (any counter value): on the next edge, grant SHALL go to the next round-robin pending requester (counter reloaded), or to IDLE with grant=0 if none.
REQ-019 There SHALL be no preemption: a non-owner request never shortens the owner's hold.
REQ-020 disp_value SHALL register the data slice of the owner selected for the next cycle, updating on every edge; it changes in the same cycle as grant and tracks the owner's data with 1-cycle latency.
REQ-021 In IDLE, disp_value SHALL hold its last value, with disp_blank=1 and disp_dp=0.
REQ-022 grant SHALL never have more than one bit set; all outputs SHALL be registered.
REQ-023 Requesters SHALL hold req until they see grant; a req pulse shorter than the wait may be lost, and this is by design.

Reset
REQ-024 rst high at an edge SHALL force: state IDLE, grant=0, disp_dp=0, disp_blank=1, disp_value=16'h0000, hold counter=0, last_owner=3.
REQ-025 Reset asserted mid-HOLD SHALL take effect at that edge regardless of counter value; arbitration restarts from requester 0 priority on the first edge after rst falls.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=0, HOLD=1), NREQ, and the default HOLD_CYCLES.
REQ-027 The round-robin next-owner search SHALL be one combinational sub-module, rr_pick (inputs req, last_owner, exclude-owner flag; outputs one-hot pick, valid).
REQ-028 The block SHALL feed the existing 4-digit scan driver directly; the up/down counter becomes requester 0.

Verification (HOLD_CYCLES=4)
REQ-029 rst 3 cycles, req=0 -> grant=0, disp_blank=1, disp_value=0000.
REQ-030 req=0001, data0=1234 -> grant=0001 one cycle later, disp_value=1234, disp_dp=0001; data0 changes to 1235 -> disp_value=1235 next edge.
REQ-031 req=1111 held, data slices AAAA/BBBB/CCCC/DDDD -> grant 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles, with no blank cycle between owners.
REQ-032 Owner 0 drops req after 1 cycle while req2 is pending -> grant=0100 on the next edge, and its hold counter restarts.
REQ-033 Only req1 held for 20 cycles -> grant stays 0010 throughout; req3 raised at cycle 20 -> grant=1000 on the next edge.
REQ-034 rst pulsed during a HOLD owned by requester 2 -> grant=0 and disp_blank=1 at that edge; with req=1111 after release -> first grant=0001.
